// File: rtl/decode_pkg.sv
// decode_pkg: shared constants and encodings for the decode stage.
//   - RV32I/RV64I major opcodes (full 7-bit values, low bits 2'b11)
//   - fmt_t: instruction format code carried on out_fmt
//   - buf_state_t: occupancy of the two-entry output buffer
package decode_pkg;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd6
    } fmt_t;

    // Encoded as {main_valid, skid_valid}.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b10,
        BUF_FULL  = 2'b11
    } buf_state_t;

endpackage

// File: rtl/rv_imm_fmt.sv
// rv_imm_fmt: combinational format classifier and immediate builder.
//   instr   in   raw 32-bit instruction
//   fmt     out  fmt_t code (FMT_NONE for unsupported encodings)
//   imm     out  immediate sign-extended from instr[31] to XLEN, 0 for R/illegal
//   illegal out  unsupported encoding
module rv_imm_fmt
    import decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit RV64_OPS = (XLEN == 64)
) (
    input  logic [31:0]     instr,
    output logic [2:0]      fmt,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    fmt_t        f;
    logic [31:0] imm32;

    always_comb begin
        f = FMT_NONE;
        case (instr[6:0])
            OPC_OP:                                   f = FMT_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR,
            OPC_MISC_MEM, OPC_SYSTEM:                 f = FMT_I;
            OPC_STORE:                                f = FMT_S;
            OPC_BRANCH:                               f = FMT_B;
            OPC_LUI, OPC_AUIPC:                       f = FMT_U;
            OPC_JAL:                                  f = FMT_J;
            OPC_OP_32:                                f = RV64_OPS ? FMT_R : FMT_NONE;
            OPC_OP_IMM_32:                            f = RV64_OPS ? FMT_I : FMT_NONE;
            default:                                  f = FMT_NONE;
        endcase
        // Compressed / non-32-bit encodings are never accepted.
        if (instr[1:0] != 2'b11) f = FMT_NONE;
    end

    // Built at 32 bits first; every format's sign bit is instr[31].
    always_comb begin
        imm32 = '0;
        case (f)
            FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            FMT_U:   imm32 = {instr[31:12], 12'b0};
            default: imm32 = '0;
        endcase
    end

    generate
        if (XLEN == 64) begin : g_x64
            assign imm = {{32{imm32[31]}}, imm32};
        end else begin : g_x32
            assign imm = imm32;
        end
    endgenerate

    assign fmt     = f;
    assign illegal = (f == FMT_NONE);

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I/RV64I decode with a 2-entry skid buffer.
//   clk, rst_n                    clock, async active-low reset
//   flush                         drop buffered beats and the current input beat
//   in_valid/in_ready/in_instr/in_pc   fetch side handshake and payload
//   out_valid/out_ready           execute side handshake
//   out_pc, out_opcode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7,
//   out_imm, out_fmt, out_illegal decoded fields of the main entry
// in_ready is a decode of registered state only, so fetch never sees a
// combinational path from out_ready.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit RV64_OPS = (XLEN == 64)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } beat_t;

    logic [2:0]      dec_fmt;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;
    beat_t           dec, main_q, skid_q;

    buf_state_t state_q, state_d;
    logic       accept, consume;
    logic       ld_main_in, ld_main_skid, ld_skid;

    rv_imm_fmt #(.XLEN(XLEN), .RV64_OPS(RV64_OPS)) u_imm_fmt (
        .instr   (in_instr),
        .fmt     (dec_fmt),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    always_comb begin
        dec.pc      = in_pc;
        dec.opcode  = in_instr[6:0];
        dec.rd      = in_instr[11:7];
        dec.rs1     = in_instr[19:15];
        dec.rs2     = in_instr[24:20];
        dec.funct3  = in_instr[14:12];
        dec.funct7  = in_instr[31:25];
        dec.imm     = dec_imm;
        dec.fmt     = dec_fmt;
        dec.illegal = dec_illegal;
    end

    assign in_ready  = (state_q != BUF_FULL);
    assign out_valid = (state_q != BUF_EMPTY);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= BUF_EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state_q)
            BUF_EMPTY: if (accept) begin
                state_d    = BUF_ONE;
                ld_main_in = 1'b1;
            end
            BUF_ONE: begin
                if (accept && consume) begin
                    ld_main_in = 1'b1;
                end else if (accept) begin
                    state_d = BUF_FULL;
                    ld_skid = 1'b1;
                end else if (consume) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_FULL: if (consume) begin
                state_d      = BUF_ONE;
                ld_main_skid = 1'b1;
            end
            default: state_d = BUF_EMPTY;
        endcase
        // Flush wins: nothing accepted this cycle may land in either entry.
        if (flush) begin
            state_d      = BUF_EMPTY;
            ld_main_in   = 1'b0;
            ld_main_skid = 1'b0;
            ld_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (ld_main_in)        main_q <= dec;
            else if (ld_main_skid) main_q <= skid_q;
            if (ld_skid)           skid_q <= dec;
        end
    end

    assign out_pc      = main_q.pc;
    assign out_opcode  = main_q.opcode;
    assign out_rd      = main_q.rd;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
    assign out_funct3  = main_q.funct3;
    assign out_funct7  = main_q.funct7;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomised checks of decode_stage at XLEN=32,
// with an XLEN=64 instance driven in lockstep for the RV64-specific vectors.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc32 = '0;
    logic [63:0] in_pc64;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_pc, out_imm;
    logic [6:0]  out_opcode, out_funct7;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3, out_fmt;

    logic        w_in_ready, w_out_valid, w_out_illegal;
    logic [63:0] w_out_pc, w_out_imm;
    logic [6:0]  w_out_opcode, w_out_funct7;
    logic [4:0]  w_out_rd, w_out_rs1, w_out_rs2;
    logic [2:0]  w_out_funct3, w_out_fmt;

    int checks = 0;
    int errors = 0;

    assign in_pc64 = {32'd0, in_pc32};

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc32),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal)
    );

    decode_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(w_in_ready), .in_instr(in_instr), .in_pc(in_pc64),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_pc(w_out_pc),
        .out_opcode(w_out_opcode), .out_rd(w_out_rd), .out_rs1(w_out_rs1), .out_rs2(w_out_rs2),
        .out_funct3(w_out_funct3), .out_funct7(w_out_funct7), .out_imm(w_out_imm),
        .out_fmt(w_out_fmt), .out_illegal(w_out_illegal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat with out_ready=1; returns at the sample point after the accept edge.
    task automatic send_one(input logic [31:0] ins);
        in_instr  = ins;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if ({out_pc, out_imm, out_opcode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7, out_fmt, out_illegal} !== '0) begin
            errors++; $display("FAIL reset_data32 pc %h imm %h fmt %0d want all 0", out_pc, out_imm, out_fmt); end
        checks++; if ({w_out_valid, ~w_in_ready, w_out_pc, w_out_imm, w_out_opcode, w_out_rd, w_out_rs1, w_out_rs2,
                       w_out_funct3, w_out_funct7, w_out_fmt, w_out_illegal} !== '0) begin
            errors++; $display("FAIL reset_data64 valid %b pc %h imm %h want 0", w_out_valid, w_out_pc, w_out_imm); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL post_reset_idle valid %b ready %b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_addi();
        in_pc32 = 32'h0000_1000;
        send_one(32'hFFF10093);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %b want 1", out_valid); end
        checks++; if (out_fmt !== 3'd1) begin errors++; $display("FAIL addi_fmt got %0d want 1", out_fmt); end
        checks++; if (out_rd !== 5'd1 || out_rs1 !== 5'd2) begin
            errors++; $display("FAIL addi_regs rd %0d rs1 %0d want 1 2", out_rd, out_rs1); end
        checks++; if (out_imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm got %h want ffffffff", out_imm); end
        checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL addi_illegal got %b want 0", out_illegal); end
        checks++; if (out_opcode !== 7'h13 || out_funct3 !== 3'd0 || out_pc !== 32'h0000_1000) begin
            errors++; $display("FAIL addi_fields opc %h f3 %0d pc %h want 13 0 00001000", out_opcode, out_funct3, out_pc); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain got %b want 0", out_valid); end
    endtask

    task automatic test_formats();
        logic [31:0] ins [8] = '{32'hFE000EE3, 32'h800002B7, 32'h00000000, 32'h0000001B,
                                 32'h0020A423, 32'hFF9FF0EF, 32'h40208133, 32'h00000010};
        logic [2:0]  f32 [8] = '{3'd3, 3'd4, 3'd6, 3'd6, 3'd2, 3'd5, 3'd0, 3'd6};
        logic [31:0] i32 [8] = '{32'hFFFFFFFC, 32'h80000000, 32'h0, 32'h0,
                                 32'h00000008, 32'hFFFFFFF8, 32'h0, 32'h0};
        logic [2:0]  f64 [8] = '{3'd3, 3'd4, 3'd6, 3'd1, 3'd2, 3'd5, 3'd0, 3'd6};
        logic [63:0] i64 [8] = '{64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFF80000000, 64'h0, 64'h0,
                                 64'h8, 64'hFFFFFFFFFFFFFFF8, 64'h0, 64'h0};
        for (int k = 0; k < 8; k++) begin
            send_one(ins[k]);
            checks++; if (out_valid !== 1'b1 || out_fmt !== f32[k] || out_imm !== i32[k] || out_illegal !== (f32[k] == 3'd6)) begin
                errors++; $display("FAIL fmt32[%0d] instr %h got v%b fmt %0d imm %h ill %b want fmt %0d imm %h",
                                   k, ins[k], out_valid, out_fmt, out_imm, out_illegal, f32[k], i32[k]); end
            checks++; if (w_out_valid !== 1'b1 || w_out_fmt !== f64[k] || w_out_imm !== i64[k] || w_out_illegal !== (f64[k] == 3'd6)) begin
                errors++; $display("FAIL fmt64[%0d] instr %h got v%b fmt %0d imm %h ill %b want fmt %0d imm %h",
                                   k, ins[k], w_out_valid, w_out_fmt, w_out_imm, w_out_illegal, f64[k], i64[k]); end
            if (k == 1) begin
                checks++; if (w_out_imm !== 64'hFFFFFFFF80000000 || w_out_rd !== 5'd5) begin
                    errors++; $display("FAIL lui64 imm %h rd %0d want ffffffff80000000 5", w_out_imm, w_out_rd); end
            end
            if (k == 3) begin
                checks++; if (w_out_rd !== 5'd0 || w_out_rs1 !== 5'd0 || w_out_opcode !== 7'h1B) begin
                    errors++; $display("FAIL opimm32_64 rd %0d rs1 %0d opc %h want 0 0 1b", w_out_rd, w_out_rs1, w_out_opcode); end
            end
            if (k == 6) begin
                checks++; if (out_funct7 !== 7'h20 || out_rs2 !== 5'd2 || out_rs1 !== 5'd1 || out_rd !== 5'd2 || w_out_funct3 !== 3'd0) begin
                    errors++; $display("FAIL sub_fields f7 %h rs2 %0d rs1 %0d rd %0d want 20 2 1 2", out_funct7, out_rs2, out_rs1, out_rd); end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got [$];
        int          n;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100093;
        tick();
        in_instr  = 32'h00200113;
        tick();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_imm !== 32'd1) begin
            errors++; $display("FAIL b2b_full ready %b valid %b imm %h want 0 1 1", in_ready, out_valid, out_imm); end
        in_instr  = 32'h00300193;
        tick();
        checks++; if (in_ready !== 1'b0 || out_imm !== 32'd1 || out_rd !== 5'd1) begin
            errors++; $display("FAIL b2b_hold ready %b imm %h rd %0d want 0 1 1", in_ready, out_imm, out_rd); end
        out_ready = 1'b1;
        n = 0;
        while (n < 10 && (in_valid || out_valid)) begin
            logic acc;
            if (out_valid) got.push_back(out_imm);
            acc = in_valid && in_ready;
            tick();
            if (acc) in_valid = 1'b0;
            n++;
        end
        checks++; if (n >= 10) begin errors++; $display("FAIL b2b_timeout cycles %0d want < 10", n); end
        checks++; if (got.size() != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", got.size()); end
        else begin
            checks++; if (got[0] !== 32'd1 || got[1] !== 32'd2 || got[2] !== 32'd3) begin
                errors++; $display("FAIL b2b_order got %0d %0d %0d want 1 2 3", got[0], got[1], got[2]); end
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00500093;
        tick();
        in_instr  = 32'h00600093;
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_prefull ready %b want 0", in_ready); end
        in_instr  = 32'h00700093;
        flush     = 1'b1;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_full valid %b ready %b want 0 1", out_valid, in_ready); end
        in_valid  = 1'b1;
        in_instr  = 32'h00800093;
        tick();
        in_instr  = 32'h00900093;
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (out_valid !== 1'b0) begin
                errors++; $display("FAIL flush_one[%0d] valid %b imm %h want 0", k, out_valid, out_imm); end
            tick();
        end
        send_one(32'h00A00093);
        checks++; if (out_valid !== 1'b1 || out_imm !== 32'd10) begin
            errors++; $display("FAIL flush_recover valid %b imm %h want 1 a", out_valid, out_imm); end
        tick();
    endtask

    task automatic test_random_reset();
        logic [31:0] qpc [$];
        logic [31:0] qimm [$];
        logic [31:0] e_imm, e_pc;
        logic [11:0] c;
        int          acc = 0;
        int          cyc = 0;
        bit          did_rst = 1'b0;
        while (acc < 1000 && cyc < 20000) begin
            cyc++;
            if (!did_rst && acc == 500) begin
                did_rst   = 1'b1;
                in_valid  = 1'b0;
                out_ready = 1'b0;
                #2;
                rst_n = 1'b0;
                #1;
                checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_imm !== '0 || out_pc !== '0 || out_fmt !== '0) begin
                    errors++; $display("FAIL async_reset valid %b ready %b imm %h pc %h fmt %0d want 0 1 0 0 0",
                                       out_valid, in_ready, out_imm, out_pc, out_fmt); end
                qpc.delete();
                qimm.delete();
                @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                tick();
                continue;
            end
            c         = 12'(acc * 37);
            in_valid  = ($urandom_range(0, 99) < 60);
            in_instr  = {c, 5'd3, 3'd0, 5'd1, 7'h13};
            in_pc32   = 32'(acc * 4);
            out_ready = ($urandom_range(0, 99) < 65);
            if (out_valid && out_ready) begin
                checks++;
                if (qimm.size() == 0) begin
                    errors++; $display("FAIL rand_stale imm %h pc %h with empty scoreboard", out_imm, out_pc);
                end else begin
                    e_imm = qimm.pop_front();
                    e_pc  = qpc.pop_front();
                    if (out_imm !== e_imm || out_pc !== e_pc || out_rd !== 5'd1 || out_rs1 !== 5'd3) begin
                        errors++; $display("FAIL rand_beat imm %h pc %h want imm %h pc %h", out_imm, out_pc, e_imm, e_pc);
                    end
                end
            end
            if (in_valid && in_ready) begin
                qimm.push_back({{20{c[11]}}, c});
                qpc.push_back(in_pc32);
                acc++;
            end
            tick();
        end
        checks++; if (cyc >= 20000) begin errors++; $display("FAIL rand_timeout accepted %0d want 1000", acc); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4 && out_valid; k++) begin
            checks++;
            if (qimm.size() == 0) begin
                errors++; $display("FAIL drain_stale imm %h", out_imm);
            end else begin
                e_imm = qimm.pop_front();
                e_pc  = qpc.pop_front();
                if (out_imm !== e_imm || out_pc !== e_pc) begin
                    errors++; $display("FAIL drain_beat imm %h pc %h want %h %h", out_imm, out_pc, e_imm, e_pc);
                end
            end
            tick();
        end
        checks++; if (qimm.size() != 0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rand_leftover queued %0d valid %b want 0 0", qimm.size(), out_valid); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_formats();
        test_back_to_back();
        test_flush();
        test_random_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised RV32I/RV64I instruction-decode stage that sits between fetch and execute in the five-stage pipeline. It splits the incoming instruction into register and function fields, builds the immediate sign-extended to XLEN, and classifies the instruction format. It flags illegal encodings and buffers results behind a 2-entry valid/ready skid buffer, so fetch sees backpressure without a combinational ready path.

## Interface
- XLEN, 32: datapath width; legal values are 32 and 64.
- RV64_OPS, (XLEN==64): when 1, OP-IMM-32 (0011011) and OP-32 (0111011) decode as legal.

- clk  input  1  pipeline clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous; discards all buffered entries and the current input beat
- in_valid  input  1  fetch beat valid
- in_ready  output  1  stage can accept; registered, equals !skid_valid
- in_instr  input  32  raw instruction
- in_pc  input  XLEN  instruction address
- out_valid  output  1  decoded beat valid
- out_ready  input  1  execute accepts
- out_pc  output  XLEN  pc of the decoded beat
- out_opcode  output  7  instr[6:0]
- out_rd / out_rs1 / out_rs2  output  5 each  instr[11:7] / [19:15] / [24:20]
- out_funct3  output  3  instr[14:12]
- out_funct7  output  7  instr[31:25]
- out_imm  output  XLEN  immediate, sign-extended from instr[31] to XLEN
- out_fmt  output  3  R=0, I=1, S=2, B=3, U=4, J=5, NONE=6
- out_illegal  output  1  unsupported encoding; out_fmt=NONE and out_imm=0

## Operation
- Opcode to format:
  - OP 0110011 → R.
  - OP-IMM, LOAD, JALR, MISC-MEM 0001111, SYSTEM 1110011 → I.
  - STORE → S.
  - BRANCH → B.
  - LUI, AUIPC → U.
  - JAL → J.
  - OP-32 → R and OP-IMM-32 → I, only when RV64_OPS=1.
- Illegal: instr[1:0]≠2'b11, or an opcode outside this set. Illegal beats still flow through the pipeline with out_illegal=1; they are never dropped.
- Immediates, with bit 31 of the raw layout sign-extended to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - U: {instr[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
  - R: imm=0.
- Decoding is combinational on the input. Decoded fields are registered; raw instructions are not stored.
- Buffer state is (main_valid, skid_valid), with states EMPTY (0,0), ONE (1,0), FULL (1,1).
  - An input is accepted when in_valid && in_ready. An output is consumed when out_valid && out_ready.
  - EMPTY + accept → ONE, with main = decoded input.
  - ONE + accept + consume → ONE, with main replaced.
  - ONE + accept, no consume → FULL, with skid = decoded input.
  - ONE + consume, no accept → EMPTY.
  - FULL + consume → ONE, with skid moved to main. No accept is possible in FULL because in_ready=0.
- out_valid = main_valid. All out_* data come from the main register.
- flush has priority over every transition: next state is EMPTY and any beat accepted in the same cycle is discarded.

## Timing
- Reset (async assert, release synchronous to clk): state EMPTY, out_valid=0, in_ready=1, every out_* data bit 0 (out_fmt=0).
- Latency: 1 cycle. An accept on edge N gives out_valid=1 after edge N.
- Throughput: 1 beat/cycle while out_ready=1.
- in_ready deasserts the cycle after entering FULL and reasserts the cycle after leaving FULL. It has no combinational path from out_ready.
- out_* data hold stable while out_valid=1 && out_ready=0.
- flush together with out_ready=1: the consume in that cycle still counts for the consumer; the stage ends EMPTY.
- Reset asserted mid-operation clears both entries immediately; no beat survives it.

## Structure
- Shared package decode_pkg holds:
  - opcode localparams (OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_SYSTEM, OPC_MISC_MEM, OPC_OP_32, OPC_OP_IMM_32);
  - the fmt_t encoding above.
- One combinational sub-module, rv_imm_fmt (parameters XLEN, RV64_OPS), produces fmt, imm and illegal from instr.
- decode_stage holds only the main and skid registers and the handshake control.

## Test plan
- XLEN=32, single beat 0xFFF10093 (addi x1,x2,-1), out_ready=1 → one cycle later: out_fmt=I, rd=1, rs1=2, out_imm=0xFFFFFFFF, out_illegal=0.
- Beat 0xFE000EE3 (beq x0,x0,-4) → fmt=B, out_imm=0xFFFFFFFC. Beat 0x800002B7 (lui x5,0x80000) with XLEN=64 → out_imm=0xFFFFFFFF80000000.
- Beat 0x00000000 → out_illegal=1, fmt=NONE, imm=0. Beat 0x0000001B → illegal at XLEN=32; fmt=I, rd=0 at XLEN=64.
- Stream 0x00100093, 0x00200113, 0x00300193 (addi x1/x2/x3) on consecutive cycles with out_ready=0:
  - in_ready=0 after the second accept and the third beat is held;
  - raising out_ready gives in order imm 1, 2, 3 with no loss or duplication.
- FULL state plus flush=1 → next cycle out_valid=0, in_ready=1; a beat presented during the flush never appears.
- Randomised valid/ready with a scoreboard over 1000 beats, plus rst_n pulsed low mid-stream → outputs return to reset values asynchronously; no stale beat appears after release.
